irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Shares the single MicroBlaze interrupt input between NUM_SRC interrupt sources.
//  The sources are the 15-bit interrupt pulse bus from the timer-interrupt generator.
//  - Latches rising edges as pending requests.
//  - Grants one request at a time, round-robin, and presents its index on irq_id.
//  - Holds irq_out until software acks, or until a timeout expires.
//  Sits between the timer-interrupt block and the MicroBlaze INTERRUPT/GPIO-ack path.
// PARAMETERS
//  NUM_SRC      15          number of interrupt sources
//  ID_W         4           width of irq_id; must satisfy 2**ID_W >= NUM_SRC
//  ACK_TIMEOUT  32'd100000  max cycles irq_out waits for an ack (1 ms at 100 MHz)
// PORTS
//  clk_100      in   1        system clock, 100 MHz
//  rst_100      in   1        asynchronous, active-high reset
//  irq_src      in   NUM_SRC  interrupt sources, synchronous to clk_100, any pulse width
//  irq_mask     in   NUM_SRC  1 = source may be granted; 0 = it stays pending, not granted
//  irq_ack      in   1        single-cycle acknowledge from software
//  overrun_clr  in   1        clears overrun and timeout_err
//  irq_out      out  1        level interrupt to MicroBlaze
//  irq_id       out  ID_W     index of the granted source; valid while irq_out=1
//  pending      out  NUM_SRC  latched, not-yet-serviced requests
//  overrun      out  NUM_SRC  sticky: an edge arrived while that bit was already pending
//  timeout_err  out  1        sticky: a grant was dropped by timeout
// BEHAVIOUR
//  Reset: all outputs 0; src_d=0; last_grant=NUM_SRC-1; state=IDLE; timeout counter=0.
//  Edge detect: rise[i] = irq_src[i] & ~src_d[i], with src_d registered every cycle.
//  Pending and overrun:
//   - rise[i] sets pending[i] at the same edge.
//   - rise[i] while pending[i]=1 and pending[i] not being cleared sets overrun[i].
//   - rise[i] in the same cycle that pending[i] is cleared: pending[i] stays 1, no overrun.
//  FSM has two states, IDLE and WAIT_ACK.
//   IDLE:
//    - If |(pending & irq_mask), pick the first set bit searching upward from
//      last_grant+1, wrapping at NUM_SRC-1 -> 0.
//    - Register irq_id and last_grant to that bit, set irq_out=1, go to WAIT_ACK.
//    - irq_ack in IDLE is ignored.
//   WAIT_ACK (timeout counter increments every cycle):
//    - irq_ack=1: clear pending[irq_id], set irq_out=0, zero the counter, go to IDLE.
//    - counter == ACK_TIMEOUT-1 without ack: same actions as an ack, plus timeout_err=1.
//    - ack and timeout in the same cycle: treated as an ack; timeout_err not set.
//    - irq_mask changes do not revoke the active grant.
//  Latency:
//   - src rises at edge N -> pending at N -> irq_out=1 after N+1 (2 cycles).
//   - After an ack, irq_out is low for at least 1 cycle before the next grant.
//  overrun_clr: zeros overrun and timeout_err; a same-cycle set wins over the clear.
//  Width: counter is 32 bits, compared against ACK_TIMEOUT-1. NUM_SRC=1 is legal.
//  Reset mid-grant: everything returns to reset values; pending requests are lost.
// STRUCTURE
//  Package irq_arb_pkg:
//   - state encoding (ST_IDLE, ST_WAIT_ACK)
//   - clog2 function used to check ID_W
//   - default ACK_TIMEOUT constant
//  Sub-module rr_pick (combinational):
//   - inputs: req[NUM_SRC], last[ID_W]
//   - outputs: gnt_vld, gnt_id[ID_W]
//   - implemented as a rotate, priority-encode, un-rotate
//  Top level holds the edge detect, pending/overrun registers, FSM and timeout counter.
// TESTING
//  1. Single source: pulse irq_src[3] for 1 cycle, mask all 1s.
//     -> irq_out=1 two cycles later with irq_id=3; ack -> irq_out=0 and pending=0.
//  2. Round-robin: bits 2, 5 and 14 rise together.
//     -> grants in order 2, 5, 14 (acking each); next rise of 2 and 5 -> grant 2 again.
//  3. Masking: irq_mask[7]=0, pulse source 7.
//     -> pending[7]=1, irq_out stays 0; set mask[7]=1 -> grant id 7 within 2 cycles.
//  4. Overrun: pulse source 4 twice before any ack.
//     -> overrun[4]=1; overrun_clr -> overrun=0.
//     A rise on 4 in the ack cycle -> pending[4] stays 1 and 4 is re-granted.
//  5. Timeout: ACK_TIMEOUT=16, grant with no ack.
//     -> irq_out falls after 16 cycles, timeout_err=1, pending bit cleared.
//  6. Reset asserted during WAIT_ACK with 3 bits pending.
//     -> all outputs 0 immediately; after release, no grant until new edges arrive.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared types and constants for the round-robin interrupt arbiter.
package irq_arb_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam logic [31:0] DEF_ACK_TIMEOUT = 32'd100000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
  parameter int NUM_SRC = 15,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               gnt_vld,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0]      start;
  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  logic [ID_W-1:0]      idx;
  logic [ID_W:0]        sum;

  always_comb begin
    start = (last >= ID_W'(NUM_SRC - 1)) ? '0 : last + ID_W'(1);
    dbl   = {req, req};
    // Rotate so bit 0 corresponds to the first candidate after 'last'.
    rot   = NUM_SRC'(dbl >> start);
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
    sum = {1'b0, idx} + {1'b0, start};
    if (sum >= (ID_W + 1)'(NUM_SRC)) sum = sum - (ID_W + 1)'(NUM_SRC);
    gnt_vld = |req;
    gnt_id  = ID_W'(sum);
  end

endmodule

// File: rtl/irq_arbiter.sv
// Merges NUM_SRC edge-triggered interrupt sources onto one level interrupt,
// granting round-robin with software ack or timeout release.
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int          NUM_SRC     = 15,
  parameter int          ID_W        = 4,
  parameter logic [31:0] ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               clk_100,
  input  logic               rst_100,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               irq_ack,
  input  logic               overrun_clr,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               timeout_err
);

  if (ID_W < clog2(NUM_SRC)) begin : g_id_w_check
    $error("irq_arbiter: ID_W too narrow for NUM_SRC");
  end

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] src_d, rise, clr_vec, ovr_set;
  logic [ID_W-1:0]    last_grant, gnt_id;
  logic [31:0]        cnt;
  logic               gnt_vld, grant_ld, done, to_hit, to_err;

  rr_pick #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_pick (
    .req    (pending & irq_mask),
    .last   (last_grant),
    .gnt_vld(gnt_vld),
    .gnt_id (gnt_id)
  );

  assign rise   = irq_src & ~src_d;
  assign to_hit = (cnt == ACK_TIMEOUT - 32'd1);

  always_comb begin
    state_nx = state;
    grant_ld = 1'b0;
    done     = 1'b0;
    to_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          grant_ld = 1'b1;
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // An ack coinciding with the timeout counts as a clean ack.
        if (irq_ack) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (to_hit) begin
          done     = 1'b1;
          to_err   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_vec[i] = done && (irq_id == ID_W'(i));
    end
    ovr_set = rise & pending & ~clr_vec;
  end

  always_ff @(posedge clk_100 or posedge rst_100) begin
    if (rst_100) begin
      state       <= ST_IDLE;
      src_d       <= '0;
      last_grant  <= ID_W'(NUM_SRC - 1);
      irq_out     <= 1'b0;
      irq_id      <= '0;
      pending     <= '0;
      overrun     <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state   <= state_nx;
      src_d   <= irq_src;
      pending <= (pending & ~clr_vec) | rise;
      overrun <= overrun_clr ? ovr_set : (overrun | ovr_set);
      if (to_err)           timeout_err <= 1'b1;
      else if (overrun_clr) timeout_err <= 1'b0;
      if (grant_ld) begin
        irq_id     <= gnt_id;
        last_grant <= gnt_id;
        irq_out    <= 1'b1;
      end
      if (done) irq_out <= 1'b0;
      if (state == ST_WAIT_ACK && !done) cnt <= cnt + 32'd1;
      else                               cnt <= '0;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: expected grant ids are queued at stimulus
// time and checked whenever irq_out rises.
module tb_irq_arbiter;
  localparam int N    = 15;
  localparam int ID_W = 4;

  logic          clk_100 = 1'b0;
  logic          rst_100 = 1'b1;
  logic [N-1:0]  irq_src = '0;
  logic [N-1:0]  irq_mask = '1;
  logic          irq_ack = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          irq_out;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_id;
  logic prev_out = 1'b0;

  irq_arbiter #(
    .NUM_SRC    (N),
    .ID_W       (ID_W),
    .ACK_TIMEOUT(32'd16)
  ) dut (
    .clk_100    (clk_100),
    .rst_100    (rst_100),
    .irq_src    (irq_src),
    .irq_mask   (irq_mask),
    .irq_ack    (irq_ack),
    .overrun_clr(overrun_clr),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .pending    (pending),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    if (irq_out === 1'b1 && prev_out !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected: irq_id=%0d with no grant expected", irq_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (irq_id !== ID_W'(exp_id)) begin
          failures++;
          $display("FAIL grant_id: got %0d expected %0d", irq_id, exp_id);
        end
      end
    end
    prev_out = irq_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_100);
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    irq_src = bits;
    tick();
    irq_src = '0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic clr_pulse();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_100 = 1'b1;
    tick();
    tick();
    rst_100 = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input int budget, input string name);
    int n = 0;
    while (irq_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL %s: irq_out=%b after %0d cycles, expected 1", name, irq_out, n);
    end
  endtask

  task automatic test_reset();
    rst_100 = 1'b1;
    tick();
    tick();
    checks++;
    if ({irq_out, irq_id, pending, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: out=%b id=%0d pend=%h ovr=%h to=%b expected all 0",
               irq_out, irq_id, pending, overrun, timeout_err);
    end
    rst_100 = 1'b0;
    repeat (4) tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: irq_out=%b expected 0", irq_out);
    end
  endtask

  task automatic test_single();
    exp_q.push_back(3);
    pulse(15'h0008);
    checks++;
    if (pending !== 15'h0008 || irq_out !== 1'b0) begin
      failures++;
      $display("FAIL single_pending: pend=%h out=%b expected 0008 and 0", pending, irq_out);
    end
    tick();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 4'd3) begin
      failures++;
      $display("FAIL single_latency: out=%b id=%0d expected 1 and 3", irq_out, irq_id);
    end
    ack_pulse();
    checks++;
    if (irq_out !== 1'b0 || pending !== '0) begin
      failures++;
      $display("FAIL single_ack: out=%b pend=%h expected 0 and 0", irq_out, pending);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(14);
    pulse(15'h4024);
    for (int k = 0; k < 3; k++) begin
      wait_grant(4, "rr_grant");
      ack_pulse();
      checks++;
      if (irq_out !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap: irq_out=%b after ack expected 0", irq_out);
      end
    end
    exp_q.push_back(2);
    exp_q.push_back(5);
    pulse(15'h0024);
    for (int k = 0; k < 2; k++) begin
      wait_grant(4, "rr_regrant");
      ack_pulse();
    end
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("FAIL rr_pending: pend=%h expected 0000", pending);
    end
  endtask

  task automatic test_mask();
    irq_mask = 15'h7F7F;
    pulse(15'h0080);
    repeat (3) tick();
    checks++;
    if (pending !== 15'h0080 || irq_out !== 1'b0) begin
      failures++;
      $display("FAIL mask_hold: pend=%h out=%b expected 0080 and 0", pending, irq_out);
    end
    exp_q.push_back(7);
    irq_mask = '1;
    wait_grant(2, "mask_release");
    ack_pulse();
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("FAIL mask_pending: pend=%h expected 0000", pending);
    end
  endtask

  task automatic test_overrun();
    exp_q.push_back(4);
    irq_src = 15'h0010;
    tick();
    irq_src = '0;
    tick();
    irq_src = 15'h0010;
    tick();
    irq_src = '0;
    checks++;
    if (overrun !== 15'h0010 || pending !== 15'h0010 || irq_out !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: ovr=%h pend=%h out=%b expected 0010 0010 1",
               overrun, pending, irq_out);
    end
    clr_pulse();
    checks++;
    if (overrun !== '0) begin
      failures++;
      $display("FAIL overrun_clr: ovr=%h expected 0000", overrun);
    end
    exp_q.push_back(4);
    irq_ack = 1'b1;
    irq_src = 15'h0010;
    tick();
    irq_ack = 1'b0;
    irq_src = '0;
    checks++;
    if (pending !== 15'h0010 || overrun !== '0 || irq_out !== 1'b0) begin
      failures++;
      $display("FAIL ack_rise: pend=%h ovr=%h out=%b expected 0010 0000 0",
               pending, overrun, irq_out);
    end
    wait_grant(3, "ack_rise_regrant");
    ack_pulse();
    checks++;
    if (pending !== '0 || overrun !== '0) begin
      failures++;
      $display("FAIL overrun_final: pend=%h ovr=%h expected 0000 0000", pending, overrun);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    exp_q.push_back(9);
    pulse(15'h0200);
    wait_grant(4, "to_grant");
    while (irq_out === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL timeout_len: irq_out held %0d cycles expected 16", n);
    end
    checks++;
    if (timeout_err !== 1'b1 || pending !== '0) begin
      failures++;
      $display("FAIL timeout_flag: to=%b pend=%h expected 1 and 0000", timeout_err, pending);
    end
    clr_pulse();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clr: to=%b expected 0", timeout_err);
    end
    exp_q.push_back(11);
    pulse(15'h0800);
    wait_grant(4, "to_ack_grant");
    repeat (15) tick();
    ack_pulse();
    checks++;
    if (irq_out !== 1'b0 || timeout_err !== 1'b0 || pending !== '0) begin
      failures++;
      $display("FAIL ack_at_timeout: out=%b to=%b pend=%h expected 0 0 0000",
               irq_out, timeout_err, pending);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    exp_q.push_back(1);
    pulse(15'h0442);
    wait_grant(4, "mid_grant");
    checks++;
    if (pending !== 15'h0442) begin
      failures++;
      $display("FAIL mid_pending: pend=%h expected 0442", pending);
    end
    #2;
    rst_100 = 1'b1;
    #1;
    checks++;
    if ({irq_out, irq_id, pending, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL mid_reset: out=%b id=%0d pend=%h ovr=%h to=%b expected all 0",
               irq_out, irq_id, pending, overrun, timeout_err);
    end
    tick();
    tick();
    rst_100 = 1'b0;
    repeat (8) tick();
    checks++;
    if (irq_out !== 1'b0 || pending !== '0) begin
      failures++;
      $display("FAIL post_reset: out=%b pend=%h expected 0 and 0000", irq_out, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_overrun();
    test_timeout();
    test_reset_mid_grant();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL grants_missing: %0d expected grants never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
